// File: rtl/bus_arbiter4_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter4_pkg
// Shared definitions for the four-way round-robin bus arbiter:
//   - FSM state encoding (ARB_IDLE / ARB_GRANT)
//   - requester count and index width
//   - rr_pick(): round-robin winner search starting at a priority pointer
// -----------------------------------------------------------------------------
package bus_arbiter4_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // First set request bit in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   // The index arithmetic wraps naturally in IDX_W bits.
   // Returns ptr when nothing is requested; callers gate on |req.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] idx;
      logic             found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ptr + IDX_W'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/bus_arbiter4_mux4.sv
// -----------------------------------------------------------------------------
// mux4
// Four-way combinational data mux for the arbitrated datapath.
// Ports:
//   sel  in   2      select (index of granted / last granted requester)
//   d0-3 in   WIDTH  requester payloads
//   y    out  WIDTH  payload of requester sel
// -----------------------------------------------------------------------------
module mux4
   import bus_arbiter4_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [IDX_W-1:0] sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/bus_arbiter4.sv
// -----------------------------------------------------------------------------
// bus_arbiter4
// Round-robin arbiter sharing one WIDTH-bit resource among four requesters.
// A grant is held until done, until the owner drops its request, or until
// MAX_HOLD cycles have elapsed. Every release spends one cycle in IDLE.
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   req      in   4      level requests, bit i = requester i
//   d0..d3   in   WIDTH  requester payloads
//   done     in   1      resource finished current transaction (GRANT only)
//   gnt      out  4      one-hot registered grant, zero when idle
//   sel      out  2      index of current / last granted requester
//   busy     out  1      high while in GRANT
//   timeout  out  1      one-cycle pulse after a MAX_HOLD forced release
//   y        out  WIDTH  payload of requester sel (combinational)
// -----------------------------------------------------------------------------
module bus_arbiter4
   import bus_arbiter4_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [WIDTH-1:0]     d0,
   input  logic [WIDTH-1:0]     d1,
   input  logic [WIDTH-1:0]     d2,
   input  logic [WIDTH-1:0]     d3,
   input  logic                 done,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [IDX_W-1:0]     sel,
   output logic                 busy,
   output logic                 timeout,
   output logic [WIDTH-1:0]     y
);

   // Hold counter is at least one bit wide so MAX_HOLD=1 still elaborates;
   // in that case it sits at 0, which already equals the last-cycle value.
   localparam int               HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0]   HOLD_LAST = HCW'(MAX_HOLD - 1);

   arb_state_e                  state_q, state_d;
   logic [NUM_REQ-1:0]          gnt_q,   gnt_d;
   logic [IDX_W-1:0]            sel_q,   sel_d;
   logic [IDX_W-1:0]            ptr_q,   ptr_d;
   logic [HCW-1:0]              cnt_q,   cnt_d;
   logic                        tmo_q,   tmo_d;

   logic [IDX_W-1:0]            winner;
   logic                        owner_req;
   logic                        expired;

   assign winner    = rr_pick(req, ptr_q);
   assign owner_req = req[sel_q];
   assign expired   = (cnt_q == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               state_d = ARB_GRANT;
               sel_d   = winner;
               gnt_d   = NUM_REQ'(1) << winner;
               cnt_d   = '0;
            end
         end
         ARB_GRANT: begin
            // done beats abandonment beats expiry; timeout only flags
            // a release that nothing else would have caused.
            if (done || !owner_req || expired) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               ptr_d   = sel_q + IDX_W'(1);
               tmo_d   = !done && owner_req;
            end else begin
               cnt_d   = cnt_q + HCW'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign busy    = (state_q == ARB_GRANT);
   assign timeout = tmo_q;

   mux4 #(.WIDTH(WIDTH)) u_mux (
      .sel (sel_q),
      .d0  (d0),
      .d1  (d1),
      .d2  (d2),
      .d3  (d3),
      .y   (y)
   );

endmodule

// File: tb/tb_bus_arbiter4.sv
module tb_bus_arbiter4;

   localparam int WIDTH    = 32;
   localparam int MAX_HOLD = 4;

   logic              clk;
   logic              rst_n;
   logic [3:0]        req;
   logic [WIDTH-1:0]  d0, d1, d2, d3;
   logic              done;
   logic [3:0]        gnt;
   logic [1:0]        sel;
   logic              busy;
   logic              timeout;
   logic [WIDTH-1:0]  y;

   int n_checks;
   int n_fail;

   bus_arbiter4 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .d0      (d0),
      .d1      (d1),
      .d2      (d2),
      .d3      (d3),
      .done    (done),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout),
      .y       (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 4'b0000;
      done  = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      tick();
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      rst_n = 1'b1;
      // grant requester 2, then yank reset between edges
      req = 4'b0100;
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL pre_reset_gnt: got %b want 0100", gnt); end
      n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL pre_reset_sel: got %0d want 2", sel); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL async_reset_gnt: got %b want 0000", gnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
      n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL async_reset_sel: got %0d want 0", sel); end
      n_checks++; if (y !== 32'h1111_0000) begin n_fail++; $display("FAIL async_reset_y: got %h want 11110000", y); end
      req = 4'b0000;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || timeout !== 1'b0 || y !== 32'h1111_0000) begin
            n_fail++;
            $display("FAIL idle_hold[%0d]: gnt=%b busy=%b sel=%0d tmo=%b y=%h want 0000 0 0 0 11110000",
                     i, gnt, busy, sel, timeout, y);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (gnt !== 4'b0100 || y !== 32'hDEAD_BEEF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant[%0d]: gnt=%b y=%h busy=%b want 0100 deadbeef 1", i, gnt, y, busy);
         end
         if (i == 2) done = 1'b1;
         tick();
      end
      done = 1'b0;
      n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: gnt=%b busy=%b want 0000 0", gnt, busy); end
      n_checks++; if (sel !== 2'd2 || y !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_sel_kept: sel=%0d y=%h want 2 deadbeef", sel, y); end
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_regrant: got %b want 0100", gnt); end
      // y follows d[sel] combinationally
      d2 = 32'h0BAD_F00D;
      #1;
      n_checks++; if (y !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL single_y_comb: got %h want 0badf00d", y); end
      d2  = 32'hDEAD_BEEF;
      req = 4'b0000;
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] seq [5];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      do_reset();
      req = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (gnt !== seq[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, gnt, seq[i]); end
         tick();
         n_checks++; if (gnt !== seq[i]) begin n_fail++; $display("FAIL rr_hold[%0d]: got %b want %b", i, gnt, seq[i]); end
         done = 1'b1;
         tick();
         done = 1'b0;
         n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d]: gnt=%b busy=%b want 0000 0", i, gnt, busy); end
         tick();
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b1000;
      tick();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_g3: got %b want 1000", gnt); end
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 4'b1001;
      tick();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_g0: got %b want 0001", gnt); end
      n_checks++; if (sel !== 2'd0 || y !== 32'h1111_0000) begin n_fail++; $display("FAIL wrap_sel: sel=%0d y=%h want 0 11110000", sel, y); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0010;
      tick();
      for (int i = 0; i < MAX_HOLD; i++) begin
         n_checks++;
         if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_hold[%0d]: gnt=%b tmo=%b want 0010 0", i, gnt, timeout);
         end
         tick();
      end
      n_checks++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: gnt=%b tmo=%b want 0000 1", gnt, timeout); end
      tick();
      n_checks++; if (timeout !== 1'b0 || gnt !== 4'b0010) begin n_fail++; $display("FAIL tmo_clear: tmo=%b gnt=%b want 0 0010", timeout, gnt); end
      // done lands on the expiry edge: done wins, no timeout
      for (int i = 0; i < MAX_HOLD - 1; i++) tick();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL tmo_last_cycle: got %b want 0010", gnt); end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_done_wins: gnt=%b tmo=%b want 0000 0", gnt, timeout); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_abandon();
      do_reset();
      req = 4'b0010;
      tick();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abandon_grant: got %b want 0010", gnt); end
      req = 4'b0000;
      tick();
      n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL abandon_release: gnt=%b busy=%b tmo=%b want 0000 0 0", gnt, busy, timeout); end
      req = 4'b0110;
      tick();
      n_checks++; if (gnt !== 4'b0100 || sel !== 2'd2) begin n_fail++; $display("FAIL abandon_next: gnt=%b sel=%0d want 0100 2", gnt, sel); end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      d0 = 32'h1111_0000;
      d1 = 32'h2222_1111;
      d2 = 32'hDEAD_BEEF;
      d3 = 32'h4444_3333;
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_abandon();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
